ctrl_pipe_hazard: RTL and testbench

Pipelined successor to the combinational MIPS control decoder. It decodes the ID-stage opcode into the WB/M/EX control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers. It also performs load-use hazard detection with bubble insertion and flushes on a taken branch. It sits beside the datapath pipeline registers and drives all stage control plus the PC/IF-ID write enables.

---
 rtl/mips_ctrl_pkg.sv | 35 +++
 rtl/ctrl_decode.sv | 68 ++++++
 rtl/ctrl_pipe_hazard.sv | 119 +++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the pipelined MIPS control path: opcodes, ALUOp
// encodings and the bit positions inside the EX, M and WB control bundles.
package mips_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam int EX_W = 4;
    localparam int M_W  = 3;
    localparam int WB_W = 2;

    // EX bundle bit positions
    localparam int EX_REGDST   = 0;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUSRC   = 3;

    // M bundle bit positions
    localparam int M_BRANCH   = 0;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 2;

    // WB bundle bit positions
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing the EX/M/WB control bundles plus
// illegal and jump flags. Unknown opcodes yield an all-zero bubble.
module ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W  = 6,
    parameter int EN_IMM = 1
) (
    input  logic [OPC_W-1:0] opc,
    output logic [EX_W-1:0]  ex,
    output logic [M_W-1:0]   m,
    output logic [WB_W-1:0]  wb,
    output logic             illegal,
    output logic             jump
);

    // Opcode to control-bundle table; every field defaults to 0.
    always_comb begin
        ex      = '0;
        m       = '0;
        wb      = '0;
        illegal = 1'b0;
        jump    = 1'b0;
        case (opc)
            OPC_W'(OPC_RTYPE): begin
                ex[EX_REGDST]                = 1'b1;
                ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_FUNCT;
                wb[WB_REGWRITE]              = 1'b1;
            end
            OPC_W'(OPC_LW): begin
                ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex[EX_ALUSRC]                = 1'b1;
                m[M_MEMREAD]                 = 1'b1;
                wb[WB_REGWRITE]              = 1'b1;
                wb[WB_MEMTOREG]              = 1'b1;
            end
            OPC_W'(OPC_SW): begin
                ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex[EX_ALUSRC]                = 1'b1;
                m[M_MEMWRITE]                = 1'b1;
            end
            OPC_W'(OPC_BEQ): begin
                ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_SUB;
                m[M_BRANCH]                  = 1'b1;
            end
            OPC_W'(OPC_ADDI): begin
                if (EN_IMM != 0) begin
                    ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALUOP_ADD;
                    ex[EX_ALUSRC]               = 1'b1;
                    wb[WB_REGWRITE]             = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_W'(OPC_J): begin
                if (EN_IMM != 0) begin
                    jump = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Pipelined control path: decodes the ID opcode, carries the control bundles
// through ID/EX, EX/MEM and MEM/WB, inserts a bubble on a load-use hazard
// and squashes ID/EX and EX/MEM on a taken branch.
module ctrl_pipe_hazard
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W  = 6,
    parameter int REG_W  = 5,
    parameter int EN_IMM = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] id_opc,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             flush,
    output logic [EX_W-1:0]  idex_ex,
    output logic [REG_W-1:0] idex_rt,
    output logic [M_W-1:0]   exmem_m,
    output logic [WB_W-1:0]  exmem_wb,
    output logic [WB_W-1:0]  memwb_wb,
    output logic             jump,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             illegal_opc
);

    logic [EX_W-1:0]  dec_ex;
    logic [M_W-1:0]   dec_m;
    logic [WB_W-1:0]  dec_wb;
    logic             dec_illegal;
    logic             dec_jump;

    logic [EX_W-1:0]  idex_ex_q;
    logic [M_W-1:0]   idex_m_q;
    logic [WB_W-1:0]  idex_wb_q;
    logic [REG_W-1:0] idex_rt_q;
    logic             idex_illegal_q;
    logic [M_W-1:0]   exmem_m_q;
    logic [WB_W-1:0]  exmem_wb_q;
    logic [WB_W-1:0]  memwb_wb_q;
    logic             stall;

    ctrl_decode #(
        .OPC_W  (OPC_W),
        .EN_IMM (EN_IMM)
    ) u_decode (
        .opc     (id_opc),
        .ex      (dec_ex),
        .m       (dec_m),
        .wb      (dec_wb),
        .illegal (dec_illegal),
        .jump    (dec_jump)
    );

    // Load-use detection; a taken branch kills the dependent instruction anyway,
    // so flush suppresses the stall. Register 0 is not special-cased.
    always_comb begin
        stall      = idex_m_q[M_MEMREAD] & ((idex_rt_q == id_rs) | (idex_rt_q == id_rt)) & ~flush;
        pc_write   = ~stall;
        ifid_write = ~stall;
        jump       = dec_jump & ~stall;
    end

    // ID/EX: decode result, replaced by a bubble on flush or stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_ex_q      <= '0;
            idex_m_q       <= '0;
            idex_wb_q      <= '0;
            idex_rt_q      <= '0;
            idex_illegal_q <= 1'b0;
        end else begin
            idex_rt_q <= id_rt;
            if (flush || stall) begin
                idex_ex_q      <= '0;
                idex_m_q       <= '0;
                idex_wb_q      <= '0;
                idex_illegal_q <= 1'b0;
            end else begin
                idex_ex_q      <= dec_ex;
                idex_m_q       <= dec_m;
                idex_wb_q      <= dec_wb;
                idex_illegal_q <= dec_illegal;
            end
        end
    end

    // EX/MEM: advances from ID/EX, squashed on a taken branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exmem_m_q  <= '0;
            exmem_wb_q <= '0;
        end else if (flush) begin
            exmem_m_q  <= '0;
            exmem_wb_q <= '0;
        end else begin
            exmem_m_q  <= idex_m_q;
            exmem_wb_q <= idex_wb_q;
        end
    end

    // MEM/WB: the branch itself is in MEM, so this stage always advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            memwb_wb_q <= '0;
        end else begin
            memwb_wb_q <= exmem_wb_q;
        end
    end

    assign idex_ex     = idex_ex_q;
    assign idex_rt     = idex_rt_q;
    assign illegal_opc = idex_illegal_q;
    assign exmem_m     = exmem_m_q;
    assign exmem_wb    = exmem_wb_q;
    assign memwb_wb    = memwb_wb_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: two instances (EN_IMM=1 and EN_IMM=0) share the
// stimulus; an instruction-level model tracks which opcode occupies each stage.
module tb_ctrl_pipe_hazard;

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_SW   = 6'b101011;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_ADDI = 6'b001000;
  localparam logic [5:0] O_J    = 6'b000010;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [5:0] id_opc = O_LW;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       flush = 1'b0;

  logic [3:0] idex_ex_o [2];
  logic [4:0] idex_rt_o [2];
  logic [2:0] exmem_m_o [2];
  logic [1:0] exmem_wb_o [2];
  logic [1:0] memwb_wb_o [2];
  logic       jump_o [2];
  logic       pc_write_o [2];
  logic       ifid_write_o [2];
  logic       illegal_o [2];

  ctrl_pipe_hazard #(.OPC_W(6), .REG_W(5), .EN_IMM(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_opc(id_opc), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .idex_ex(idex_ex_o[0]), .idex_rt(idex_rt_o[0]),
    .exmem_m(exmem_m_o[0]), .exmem_wb(exmem_wb_o[0]), .memwb_wb(memwb_wb_o[0]),
    .jump(jump_o[0]), .pc_write(pc_write_o[0]), .ifid_write(ifid_write_o[0]),
    .illegal_opc(illegal_o[0])
  );

  ctrl_pipe_hazard #(.OPC_W(6), .REG_W(5), .EN_IMM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_opc(id_opc), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .idex_ex(idex_ex_o[1]), .idex_rt(idex_rt_o[1]),
    .exmem_m(exmem_m_o[1]), .exmem_wb(exmem_wb_o[1]), .memwb_wb(memwb_wb_o[1]),
    .jump(jump_o[1]), .pc_write(pc_write_o[1]), .ifid_write(ifid_write_o[1]),
    .illegal_opc(illegal_o[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which instruction sits in each stage (v=0 means bubble).
  bit         known = 0;
  bit         s_idex_v [2];
  logic [5:0] s_idex_opc [2];
  logic [4:0] s_idex_rt [2];
  bit         s_exmem_v [2];
  logic [5:0] s_exmem_opc [2];
  bit         s_memwb_v [2];
  logic [5:0] s_memwb_opc [2];

  function automatic bit is_legal(input logic [5:0] o, input bit en);
    return (o == O_R) || (o == O_LW) || (o == O_SW) || (o == O_BEQ) ||
           (en && ((o == O_ADDI) || (o == O_J)));
  endfunction

  // Returns {wb[1:0], m[2:0], ex[3:0]} built from named control fields.
  function automatic logic [8:0] bundles(input bit v, input logic [5:0] o, input bit en);
    int regdst = 0, aluop = 0, alusrc = 0;
    int branch = 0, memread = 0, memwrite = 0;
    int regwrite = 0, memtoreg = 0;
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    if (v && is_legal(o, en)) begin
      if (o == O_R)    begin regdst = 1; aluop = 2; regwrite = 1; end
      if (o == O_LW)   begin alusrc = 1; memread = 1; regwrite = 1; memtoreg = 1; end
      if (o == O_SW)   begin alusrc = 1; memwrite = 1; end
      if (o == O_BEQ)  begin aluop = 1; branch = 1; end
      if (o == O_ADDI) begin alusrc = 1; regwrite = 1; end
    end
    ex = 4'(alusrc * 8 + aluop * 2 + regdst);
    m  = 3'(memwrite * 4 + memread * 2 + branch);
    wb = 2'(memtoreg * 2 + regwrite);
    return {wb, m, ex};
  endfunction

  // driver: apply one cycle of inputs, check both instances, advance the model
  task automatic step(input logic [5:0] o, input logic [4:0] rs, input logic [4:0] rt,
                      input logic fl, input logic rn);
    bit         st [2];
    logic [8:0] b_idex, b_exmem, b_memwb;
    id_opc = o; id_rs = rs; id_rt = rt; flush = fl; rst_n = rn;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bit en;
      en = (i == 1);
      st[i] = s_idex_v[i] && (s_idex_opc[i] == O_LW) &&
              ((s_idex_rt[i] == rs) || (s_idex_rt[i] == rt)) && !fl;
      b_idex  = bundles(s_idex_v[i], s_idex_opc[i], en);
      b_exmem = bundles(s_exmem_v[i], s_exmem_opc[i], en);
      b_memwb = bundles(s_memwb_v[i], s_memwb_opc[i], en);
      if (known) begin
        chk($sformatf("pc_write[%0d]", i), 32'(pc_write_o[i]), 32'(!st[i]));
        chk($sformatf("ifid_write[%0d]", i), 32'(ifid_write_o[i]), 32'(!st[i]));
        chk($sformatf("jump[%0d]", i), 32'(jump_o[i]), 32'(en && (o == O_J) && !st[i]));
        chk($sformatf("idex_ex[%0d]", i), 32'(idex_ex_o[i]), 32'(b_idex[3:0]));
        chk($sformatf("idex_rt[%0d]", i), 32'(idex_rt_o[i]), 32'(s_idex_rt[i]));
        chk($sformatf("illegal[%0d]", i), 32'(illegal_o[i]),
            32'(s_idex_v[i] && !is_legal(s_idex_opc[i], en)));
        chk($sformatf("exmem_m[%0d]", i), 32'(exmem_m_o[i]), 32'(b_exmem[6:4]));
        chk($sformatf("exmem_wb[%0d]", i), 32'(exmem_wb_o[i]), 32'(b_exmem[8:7]));
        chk($sformatf("memwb_wb[%0d]", i), 32'(memwb_wb_o[i]), 32'(b_memwb[8:7]));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rn) begin
        s_idex_v[i] = 0; s_idex_opc[i] = '0; s_idex_rt[i] = '0;
        s_exmem_v[i] = 0; s_exmem_opc[i] = '0;
        s_memwb_v[i] = 0; s_memwb_opc[i] = '0;
      end else begin
        s_memwb_v[i] = s_exmem_v[i]; s_memwb_opc[i] = s_exmem_opc[i];
        if (fl) begin
          s_exmem_v[i] = 0;
        end else begin
          s_exmem_v[i] = s_idex_v[i]; s_exmem_opc[i] = s_idex_opc[i];
        end
        s_idex_v[i] = !fl && !st[i];
        s_idex_opc[i] = o;
        s_idex_rt[i] = rt;
      end
    end
    if (!rn) known = 1;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset held two cycles with LW presented
    step(O_LW, 5'd1, 5'd2, 1'b0, 1'b0);
    step(O_LW, 5'd1, 5'd2, 1'b0, 1'b0);
    chk("rst_idex_ex", 32'(idex_ex_o[1]), 32'h0);
    chk("rst_memwb_wb", 32'(memwb_wb_o[1]), 32'h0);
    #1 chk("rst_pc_write", 32'(pc_write_o[1]), 32'h1);

    // stream R, LW, SW, BEQ without register overlap
    step(O_R, 5'd1, 5'd2, 1'b0, 1'b1);
    chk("str_c1_idex_ex", 32'(idex_ex_o[1]), 32'h5);
    step(O_LW, 5'd3, 5'd4, 1'b0, 1'b1);
    chk("str_c2_idex_ex", 32'(idex_ex_o[1]), 32'h8);
    chk("str_c2_exmem_wb", 32'(exmem_wb_o[1]), 32'h1);
    step(O_SW, 5'd6, 5'd7, 1'b0, 1'b1);
    chk("str_c3_exmem_m", 32'(exmem_m_o[1]), 32'h2);
    chk("str_c3_memwb_wb", 32'(memwb_wb_o[1]), 32'h1);
    step(O_BEQ, 5'd8, 5'd9, 1'b0, 1'b1);
    chk("str_c4_exmem_m", 32'(exmem_m_o[1]), 32'h4);
    chk("str_c4_memwb_wb", 32'(memwb_wb_o[1]), 32'h3);

    // load-use: LW rt=5 in ID/EX, dependent rs=5 in ID
    step(O_LW, 5'd1, 5'd5, 1'b0, 1'b1);
    id_opc = O_R; id_rs = 5'd5; id_rt = 5'd7; flush = 1'b0;
    #1 chk("lu_pc_write", 32'(pc_write_o[1]), 32'h0);
    chk("lu_ifid_write", 32'(ifid_write_o[1]), 32'h0);
    step(O_R, 5'd5, 5'd7, 1'b0, 1'b1);
    chk("lu_bubble_idex_ex", 32'(idex_ex_o[1]), 32'h0);
    #1 chk("lu_release_pc_write", 32'(pc_write_o[1]), 32'h1);
    step(O_R, 5'd5, 5'd7, 1'b0, 1'b1);
    chk("lu_bubble_exmem_m", 32'(exmem_m_o[1]), 32'h0);

    // flush overrides a pending stall
    step(O_LW, 5'd1, 5'd5, 1'b0, 1'b1);
    id_opc = O_R; id_rs = 5'd5; id_rt = 5'd0; flush = 1'b1;
    #1 chk("fl_pc_write", 32'(pc_write_o[1]), 32'h1);
    step(O_R, 5'd5, 5'd0, 1'b1, 1'b1);
    chk("fl_idex_ex", 32'(idex_ex_o[1]), 32'h0);
    chk("fl_exmem_m", 32'(exmem_m_o[1]), 32'h0);

    // illegal opcode, ADDI and J under both EN_IMM settings
    step(6'b111111, 5'd1, 5'd2, 1'b0, 1'b1);
    chk("ill_flag", 32'(illegal_o[1]), 32'h1);
    chk("ill_idex_ex", 32'(idex_ex_o[1]), 32'h0);
    step(O_ADDI, 5'd1, 5'd2, 1'b0, 1'b1);
    chk("addi_idex_ex", 32'(idex_ex_o[1]), 32'h8);
    chk("addi_noimm_ill", 32'(illegal_o[0]), 32'h1);
    step(O_R, 5'd1, 5'd2, 1'b0, 1'b1);
    chk("addi_exmem_wb", 32'(exmem_wb_o[1]), 32'h1);
    id_opc = O_J; id_rs = 5'd1; id_rt = 5'd2; flush = 1'b0;
    #1 chk("j_jump", 32'(jump_o[1]), 32'h1);
    step(O_J, 5'd1, 5'd2, 1'b0, 1'b1);
    chk("j_idex_ex", 32'(idex_ex_o[1]), 32'h0);

    // back-to-back loads that depend on each other
    step(O_LW, 5'd1, 5'd3, 1'b0, 1'b1);
    step(O_LW, 5'd3, 5'd4, 1'b0, 1'b1);
    step(O_LW, 5'd3, 5'd4, 1'b0, 1'b1);
    step(O_LW, 5'd4, 5'd6, 1'b0, 1'b1);
    step(O_LW, 5'd4, 5'd6, 1'b0, 1'b1);

    // randomized traffic with small register space to provoke hazards
    for (int n = 0; n < 600; n++) begin
      logic [5:0] o;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 8:    o = O_R;
        1, 2, 9: o = O_LW;
        3:       o = O_SW;
        4:       o = O_BEQ;
        5:       o = O_ADDI;
        6:       o = O_J;
        default: o = 6'($urandom_range(0, 63));
      endcase
      step(o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 49) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
